// File: rtl/dnn_infer_ctrl.sv
// rtl/dnn_infer_ctrl.sv - DNN inference sequencer with watchdog and 10-way signed argmax
module dnn_infer_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         img_valid,
  output logic                         img_ready,
  output logic                         eng_reset,
  output logic                         eng_start,
  input  logic                         eng_done,
  input  logic signed [DATA_WIDTH-1:0] eng_out [9:0],
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3:0]                   res_class,
  output logic signed [DATA_WIDTH-1:0] res_score,
  output logic                         busy,
  output logic                         err_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    ARGMAX = 3'd4,
    RESULT = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t                         state_q, state_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d, cnt_inc;
  logic signed [DATA_WIDTH-1:0]   snap_q [9:0];
  logic signed [DATA_WIDTH-1:0]   snap_d [9:0];
  logic signed [DATA_WIDTH-1:0]   best_q, best_d, cand, new_best;
  logic [3:0]                     bestidx_q, bestidx_d, new_idx;
  logic [3:0]                     idx_q, idx_d;
  logic [3:0]                     res_class_q, res_class_d;
  logic signed [DATA_WIDTH-1:0]   res_score_q, res_score_d;
  logic                           err_q, err_d;
  logic                           armed_q;
  logic                           wins;

  // State and datapath registers; reset abandons any operation silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      for (int i = 0; i < 10; i++) snap_q[i] <= '0;
      best_q      <= '0;
      bestidx_q   <= '0;
      idx_q       <= '0;
      res_class_q <= '0;
      res_score_q <= '0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      best_q      <= best_d;
      bestidx_q   <= bestidx_d;
      idx_q       <= idx_d;
      res_class_q <= res_class_d;
      res_score_q <= res_score_d;
      err_q       <= err_d;
      armed_q     <= 1'b1;
    end
  end

  // Next-state, watchdog and one-compare-per-cycle argmax; strict > keeps the lowest index on ties.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    snap_d      = snap_q;
    best_d      = best_q;
    bestidx_d   = bestidx_q;
    idx_d       = idx_q;
    res_class_d = res_class_q;
    res_score_d = res_score_q;
    err_d       = err_q;
    cnt_inc     = cnt_q + 1'b1;
    cand        = snap_q[idx_q];
    wins        = (cand > best_q);
    new_best    = wins ? cand  : best_q;
    new_idx     = wins ? idx_q : bestidx_q;
    case (state_q)
      IDLE: begin
        if (img_valid && armed_q) begin
          state_d = CLEAR;
          err_d   = 1'b0;
        end
      end
      CLEAR: state_d = START;
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (eng_done) begin
          snap_d    = eng_out;
          best_d    = eng_out[0];
          bestidx_d = 4'd0;
          idx_d     = 4'd1;
          state_d   = ARGMAX;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) state_d = ERROR;
        end
      end
      ARGMAX: begin
        best_d    = new_best;
        bestidx_d = new_idx;
        idx_d     = idx_q + 4'd1;
        if (idx_q == 4'd9) begin
          idx_d       = 4'd0;
          res_class_d = new_idx;
          res_score_d = new_best;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) state_d = IDLE;
      end
      ERROR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/strobe outputs decode the state register only; armed_q holds img_ready low in reset.
  always_comb begin
    img_ready   = (state_q == IDLE) && armed_q;
    eng_reset   = (state_q == CLEAR) || (state_q == ERROR);
    eng_start   = (state_q == START);
    res_valid   = (state_q == RESULT);
    busy        = (state_q != IDLE);
    res_class   = res_class_q;
    res_score   = res_score_q;
    err_timeout = err_q;
  end

endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// tb/tb_dnn_infer_ctrl.sv - table-driven bench for dnn_infer_ctrl
module tb_dnn_infer_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              img_valid, img_ready, eng_reset, eng_start, eng_done;
  logic signed [7:0] eng_out [9:0];
  logic              res_valid, res_ready, busy, err_timeout;
  logic [3:0]        res_class;
  logic signed [7:0] res_score;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [79:0]       scores;
    int                cls;
    logic signed [7:0] score;
    bit                noise;
    int                bp;
  } vec_t;

  vec_t vecs [6];

  dnn_infer_ctrl #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .img_valid(img_valid), .img_ready(img_ready),
    .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
    .eng_out(eng_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_score(res_score), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [79:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    logic [79:0] r;
    r = {8'(a9), 8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    return r;
  endfunction

  task automatic set_out(input logic [79:0] s);
    for (int i = 0; i < 10; i++) eng_out[i] = s[8*i +: 8];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_img_ready"}, int'(img_ready), 0);
    chk({tag, "_eng_reset"}, int'(eng_reset), 0);
    chk({tag, "_eng_start"}, int'(eng_start), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err_timeout), 0);
    chk({tag, "_class"}, int'(res_class), 0);
    chk({tag, "_score"}, int'(res_score), 0);
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (!img_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready_wait"}, int'(img_ready), 1);
  endtask

  // Accept at T, check T+1/T+2 strobes; returns at T+3 negedge (first RUN cycle).
  task automatic accept_and_start(input string tag, input bit noise);
    wait_ready(tag);
    img_valid = 1'b1;
    if (noise) res_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_T1_eng_reset"}, int'(eng_reset), 1);
    chk({tag, "_T1_eng_start"}, int'(eng_start), 0);
    chk({tag, "_T1_img_ready"}, int'(img_ready), 0);
    chk({tag, "_T1_busy"}, int'(busy), 1);
    chk({tag, "_T1_err_cleared"}, int'(err_timeout), 0);
    img_valid = 1'b0;
    if (noise) eng_done = 1'b1;
    @(negedge clk);
    chk({tag, "_T2_eng_start"}, int'(eng_start), 1);
    chk({tag, "_T2_eng_reset"}, int'(eng_reset), 0);
    @(negedge clk);
    eng_done = 1'b0;
    chk({tag, "_T3_eng_start"}, int'(eng_start), 0);
    chk({tag, "_T3_busy"}, int'(busy), 1);
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    accept_and_start(tag, v.noise);
    repeat (2) @(negedge clk);
    eng_done = 1'b1;
    set_out(v.scores);
    @(negedge clk);
    eng_done = 1'b0;
    set_out(~v.scores);
    for (int k = 1; k <= 9; k++) begin
      chk({tag, "_argmax_no_valid"}, int'(res_valid), 0);
      @(negedge clk);
    end
    chk({tag, "_D10_res_valid"}, int'(res_valid), 1);
    chk({tag, "_class"}, int'(res_class), v.cls);
    chk({tag, "_score"}, int'(res_score), int'(v.score));
    for (int k = 0; k < v.bp; k++) begin
      img_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_bp_valid"}, int'(res_valid), 1);
      chk({tag, "_bp_class"}, int'(res_class), v.cls);
      chk({tag, "_bp_score"}, int'(res_score), int'(v.score));
      chk({tag, "_bp_img_ready"}, int'(img_ready), 0);
      chk({tag, "_bp_eng_start"}, int'(eng_start), 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    img_valid = 1'b0;
    res_ready = 1'b0;
    set_out('0);
    chk({tag, "_idle_valid"}, int'(res_valid), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_ready"}, int'(img_ready), 1);
    chk({tag, "_keep_class"}, int'(res_class), v.cls);
    chk({tag, "_keep_score"}, int'(res_score), int'(v.score));
  endtask

  initial begin
    int pulses;
    vecs[0] = '{pk(3, -2, 5, 0, 1, 4, 5, 100, -7, 2), 7, 8'sd100, 1'b0, 0};
    vecs[1] = '{pk(1, 10, 50, -3, 49, 0, 50, 7, 2, 1), 2, 8'sd50, 1'b0, 0};
    vecs[2] = '{pk(-128, -128, -128, -128, -128, -128, -128, -128, -128, -127), 9, -8'sd127, 1'b0, 0};
    vecs[3] = '{pk(127, 0, -1, 3, 9, 127, 5, 126, 0, -128), 0, 8'sd127, 1'b1, 0};
    vecs[4] = '{pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 8'sd0, 1'b0, 0};
    vecs[5] = '{pk(-50, -50, -50, -50, -50, -50, -50, -50, -1, 0), 9, 8'sd0, 1'b0, 20};

    rst = 1'b0; img_valid = 1'b0; eng_done = 1'b0; res_ready = 1'b0;
    set_out('0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_img_ready", int'(img_ready), 1);
    chk("post_reset_eng_start", int'(eng_start), 0);

    for (int i = 0; i < 6; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Watchdog: no eng_done for 16 RUN cycles.
    accept_and_start("tmo", 1'b0);
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      chk("tmo_run_busy", int'(busy), 1);
      chk("tmo_run_no_reset", int'(eng_reset), 0);
      @(negedge clk);
    end
    chk("tmo_error_eng_reset", int'(eng_reset), 1);
    chk("tmo_error_no_valid", int'(res_valid), 0);
    @(negedge clk);
    chk("tmo_err_flag", int'(err_timeout), 1);
    chk("tmo_idle_ready", int'(img_ready), 1);
    chk("tmo_no_valid", int'(res_valid), 0);
    for (int k = 0; k < 4; k++) begin
      if (eng_reset) pulses++;
      if (res_valid) pulses += 100;
      @(negedge clk);
    end
    chk("tmo_quiet_after", pulses, 0);
    chk("tmo_err_sticky", int'(err_timeout), 1);
    run_txn("after_tmo", vecs[0]);

    // Reset in the middle of ARGMAX (D+4).
    accept_and_start("rstmid", 1'b0);
    eng_done = 1'b1;
    set_out(vecs[1].scores);
    @(negedge clk);
    eng_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("rstmid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_img_ready", int'(img_ready), 1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (res_valid || eng_start || busy || err_timeout) pulses++;
      @(negedge clk);
    end
    chk("rstmid_quiet_after", pulses, 0);
    run_txn("after_rst", vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dnn_infer_ctrl.md
DNN_INFER_CTRL -- requirements
Module: dnn_infer_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of signed engine class scores.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, the maximum number of RUN cycles without eng_done.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, watchdog counter width; it SHALL satisfy TIMEOUT_CYCLES < 2**CNT_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port img_valid, input, 1 bit, indicating that an image is loaded in memory and an inference is requested.
REQ-007 SHALL have port img_ready, output, 1 bit, indicating that the controller accepts a request.
REQ-008 SHALL have port eng_reset, output, 1 bit, a synchronous clear pulse to the inference engine.
REQ-009 SHALL have port eng_start, output, 1 bit, a start pulse to the inference engine.
REQ-010 SHALL have port eng_done, input, 1 bit, the engine completion flag.
REQ-011 SHALL have port eng_out[9:0], input, signed DATA_WIDTH each, the engine class scores.
REQ-012 SHALL have port res_valid, output, 1 bit, indicating that a result is available.
REQ-013 SHALL have port res_ready, input, 1 bit, indicating that the consumer accepts the result.
REQ-014 SHALL have port res_class, output, 4 bits, the winning class index 0..9.
REQ-015 SHALL have port res_score, output, signed DATA_WIDTH, the winning score.
REQ-016 SHALL have port busy, output, 1 bit, high whenever state != IDLE.
REQ-017 SHALL have port err_timeout, output, 1 bit, a sticky watchdog error flag.

Function
REQ-018 SHALL implement states IDLE, CLEAR, START, RUN, ARGMAX, RESULT, ERROR, held in a registered state variable.
REQ-019 SHALL drive img_ready=1 only in IDLE.
REQ-020 SHALL accept a request on a cycle T with img_valid&img_ready, move to CLEAR, and clear err_timeout in the same edge.
REQ-021 SHALL, in CLEAR (cycle T+1), drive eng_reset=1 for exactly one cycle, then move to START.
REQ-022 SHALL, in START (cycle T+2), drive eng_start=1 for exactly one cycle, clear the watchdog, then move to RUN.
REQ-023 SHALL, in RUN, increment the watchdog counter every cycle in which eng_done=0.
REQ-024 SHALL ignore eng_done in every state other than RUN.
REQ-025 SHALL, when eng_done=1 is sampled in RUN at cycle D, snapshot all ten eng_out values, load best=snap[0], bestidx=0, idx=1, and move to ARGMAX.
REQ-026 SHALL, in ARGMAX, compare snap[idx] against best as signed values in one cycle per index, for idx 1..9 (cycles D+1..D+9).
REQ-027 SHALL replace best and bestidx only on a strictly-greater result, so that on ties the lowest index wins.
REQ-028 SHALL, after idx=9, move to RESULT and load res_class/res_score; res_valid SHALL be first high at cycle D+10 (10-cycle latency from done).
REQ-029 SHALL, in RESULT, hold res_valid=1 with res_class and res_score stable until res_ready=1, then move to IDLE on that edge.
REQ-030 SHALL ignore res_ready whenever res_valid=0.
REQ-031 SHALL have res_class and res_score change only when RESULT is entered; otherwise they retain the last result.
REQ-032 SHALL, when the watchdog reaches TIMEOUT_CYCLES in RUN with eng_done=0, move to ERROR.
REQ-033 SHALL give eng_done=1 priority over timeout when both occur in the same cycle.
REQ-034 SHALL, in ERROR, drive eng_reset=1 for one cycle, set err_timeout=1, and move to IDLE without asserting res_valid.
REQ-035 SHALL not accept img_valid while busy; such requests remain pending at the source.
REQ-036 SHALL decode eng_start, eng_reset, img_ready, res_valid and busy from the state register only, with no combinational path from inputs.

Reset
REQ-037 SHALL, while rst=0, immediately force state=IDLE, counters, snapshot, best and idx to 0.
REQ-038 SHALL, while rst=0, force all outputs to 0 (img_ready becomes 1 after release).
REQ-039 SHALL, on assertion of rst mid-operation (any state), abandon the operation with no result and no error flag.
REQ-040 SHALL, after rst release, not issue eng_start until a new request is accepted.

Verification
REQ-041 SHALL cover the basic scenario: accept at T; done at D; eng_out[7]=100, all others ≤5 -> eng_reset at T+1, eng_start at T+2, res_valid at D+10, res_class=7, res_score=100.
REQ-042 SHALL cover the tie scenario: eng_out[2]=eng_out[6]=50 as maximum -> res_class=2, res_score=50.
REQ-043 SHALL cover the all-negative scenario: all -128 except eng_out[9]=-127 -> res_class=9, res_score=-127.
REQ-044 SHALL cover backpressure: res_ready=0 for 20 cycles with img_valid=1 -> res_valid and outputs stable, img_ready=0, no new eng_start; res_ready=1 -> IDLE next cycle.
REQ-045 SHALL cover timeout: TIMEOUT_CYCLES=16 with eng_done never asserted -> ERROR after 16 RUN cycles, single eng_reset pulse, err_timeout=1, no res_valid; next accepted request clears err_timeout.
REQ-046 SHALL cover reset mid-ARGMAX: rst=0 at D+4 -> all outputs 0 immediately; after release, img_ready=1 and no res_valid.
